// File: rtl/serial_frame_rx_if.sv
// Serial receiver bundle: line in, recovered word and strobes out.
interface serial_frame_rx_if #(
  parameter int M = 5
);
  logic         bit_in;
  logic [M-1:0] data_out;
  logic         data_valid;
  logic         frame_err;
  logic         busy;

  modport master (output bit_in, input data_out, data_valid, frame_err, busy);
  modport slave  (input bit_in, output data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/serial_frame_rx.sv
// Start/data/stop frame receiver for an idle-high line that is synchronous to clk.
// Detects the start bit, re-checks it, samples M bits LSB-first, checks the stop
// bit, and emits a one-cycle data_valid or frame_err strobe.
module serial_frame_rx #(
  parameter int M            = 5,
  parameter int CLKS_PER_BIT = 4
) (
  input logic              clk,
  input logic              reset,
  serial_frame_rx_if.slave rx
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [M-1:0]     sh_q, sh_d;
  logic [M-1:0]     data_q, data_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;

  // Shift a new bit in at the MSB end; written as a loop so M==1 elaborates.
  function automatic logic [M-1:0] shift_in(input logic [M-1:0] sh, input logic b);
    logic [M-1:0] r;
    r = sh;
    for (int i = 0; i < M - 1; i++) begin
      r[i] = sh[i+1];
    end
    r[M-1] = b;
    return r;
  endfunction

  // Next-state and datapath updates; strobes default low so they last one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx.bit_in) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx.bit_in) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;  // false start: line went back high
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = shift_in(sh_q, rx.bit_in);
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx.bit_in) begin
            data_d  = sh_q;
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off new starts until the line has returned high.
        if (rx.bit_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = dv_q;
  assign rx.frame_err  = fe_q;
  assign rx.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: M=5/CPB=4 instance driven directly,
// plus an M=8/CPB=1 instance fed by a parallel-in/serial-out register.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  serial_frame_rx_if #(.M(5)) rx_if ();
  serial_frame_rx_if #(.M(8)) if8 ();

  serial_frame_rx #(.M(5), .CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_if)
  );

  serial_frame_rx #(.M(8), .CLKS_PER_BIT(1)) dut8 (
    .clk   (clk),
    .reset (reset),
    .rx    (if8)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge E, cyc == E.
  always @(posedge clk) cyc <= cyc + 1;

  // Serializer feeding the CPB=1 instance: LSB out, ones shifted in.
  logic       piso_load = 1'b0;
  logic [9:0] piso_q    = '1;
  always @(posedge clk) begin
    if (piso_load) piso_q <= {1'b1, 8'hA5, 1'b0};
    else           piso_q <= {1'b1, piso_q[9:1]};
  end
  assign if8.bit_in = piso_q[0];

  // Output monitors, sampled on the falling edge.
  int         dv_cnt = 0, fe_cnt = 0, busy_cnt = 0, both_cnt = 0;
  int         last_dv_cyc = 0, prev_dv_cyc = 0, last_fe_cyc = 0;
  logic [4:0] last_dv_data = '0, prev_dv_data = '0;
  int         dv8_cnt = 0, fe8_cnt = 0, busy8_cnt = 0, last_dv8_cyc = 0;

  always @(negedge clk) begin
    if (rx_if.data_valid) begin
      dv_cnt++;
      prev_dv_cyc  = last_dv_cyc;
      prev_dv_data = last_dv_data;
      last_dv_cyc  = cyc;
      last_dv_data = rx_if.data_out;
    end
    if (rx_if.frame_err) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (rx_if.data_valid && rx_if.frame_err) both_cnt++;
    if (rx_if.busy) busy_cnt++;
    if (if8.data_valid) begin
      dv8_cnt++;
      last_dv8_cyc = cyc;
    end
    if (if8.frame_err) fe8_cnt++;
    if (if8.busy) busy8_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the first nticks cycles of a CPB=4 frame; e0 is the start-detect edge.
  task automatic drive_frame(input logic [4:0] d, input logic stop, input int nticks,
                             output int e0);
    int b;
    e0 = 0;
    for (int t = 0; t < nticks; t++) begin
      b = t / 4;
      if (b == 0)      rx_if.bit_in = 1'b0;
      else if (b <= 5) rx_if.bit_in = d[b-1];
      else             rx_if.bit_in = stop;
      tick(1);
      if (t == 0) e0 = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, e1, l, dv0, fe0, bz0, dv80, fe80, bz80;

    reset        = 1'b1;
    rx_if.bit_in = 1'b1;
    tick(3);
    check_eq("rst_data_out", rx_if.data_out, 5'h00);
    check_eq("rst_valid",    rx_if.data_valid, 1'b0);
    check_eq("rst_ferr",     rx_if.frame_err, 1'b0);
    check_eq("rst_busy",     rx_if.busy, 1'b0);
    reset = 1'b0;
    tick(10);

    // 1: good frame 0x0D
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_frame(5'h0D, 1'b1, 28, e0);
    rx_if.bit_in = 1'b1;
    tick(4);
    check_eq("t1_dv_count", dv_cnt - dv0, 1);
    check_eq("t1_fe_count", fe_cnt - fe0, 0);
    check_eq("t1_dv_time",  last_dv_cyc, e0 + 27);
    check_eq("t1_data",     rx_if.data_out, 5'h0D);
    check_eq("t1_busy",     rx_if.busy, 1'b0);

    // 2: stop bit low, line held low
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_frame(5'h15, 1'b0, 28, e0);
    tick(8);
    check_eq("t2_fe_count", fe_cnt - fe0, 1);
    check_eq("t2_fe_time",  last_fe_cyc, e0 + 27);
    check_eq("t2_dv_count", dv_cnt - dv0, 0);
    check_eq("t2_data_kept", rx_if.data_out, 5'h0D);
    check_eq("t2_busy_break", rx_if.busy, 1'b1);
    rx_if.bit_in = 1'b1;
    tick(1);
    check_eq("t2_busy_release", rx_if.busy, 1'b0);

    // 3: one-cycle glitch
    dv0 = dv_cnt; fe0 = fe_cnt; bz0 = busy_cnt;
    rx_if.bit_in = 1'b0;
    tick(1);
    rx_if.bit_in = 1'b1;
    tick(2);
    check_eq("t3_busy_e2", rx_if.busy, 1'b1);
    tick(1);
    check_eq("t3_busy_e3", rx_if.busy, 1'b0);
    tick(4);
    check_eq("t3_busy_cycles", busy_cnt - bz0, 3);
    check_eq("t3_dv_count", dv_cnt - dv0, 0);
    check_eq("t3_fe_count", fe_cnt - fe0, 0);

    // 4: back-to-back 0x1F then 0x00
    dv0 = dv_cnt;
    drive_frame(5'h1F, 1'b1, 28, e0);
    drive_frame(5'h00, 1'b1, 28, e1);
    rx_if.bit_in = 1'b1;
    tick(4);
    check_eq("t4_dv_count", dv_cnt - dv0, 2);
    check_eq("t4_first_time", prev_dv_cyc, e0 + 27);
    check_eq("t4_spacing", last_dv_cyc - prev_dv_cyc, 28);
    check_eq("t4_first_data", prev_dv_data, 5'h1F);
    check_eq("t4_second_data", last_dv_data, 5'h00);
    check_eq("t4_data_out", rx_if.data_out, 5'h00);

    // 5: reset mid-frame
    drive_frame(5'h0B, 1'b1, 28, e0);
    rx_if.bit_in = 1'b1;
    tick(2);
    check_eq("t5_pre_data", rx_if.data_out, 5'h0B);
    dv0 = dv_cnt; fe0 = fe_cnt;
    drive_frame(5'h0A, 1'b1, 14, e0);
    reset        = 1'b1;
    rx_if.bit_in = 1'b1;
    tick(1);
    check_eq("t5_rst_data", rx_if.data_out, 5'h00);
    check_eq("t5_rst_valid", rx_if.data_valid, 1'b0);
    check_eq("t5_rst_ferr", rx_if.frame_err, 1'b0);
    check_eq("t5_rst_busy", rx_if.busy, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(40);
    check_eq("t5_abort_dv", dv_cnt - dv0, 0);
    check_eq("t5_abort_fe", fe_cnt - fe0, 0);
    drive_frame(5'h12, 1'b1, 28, e0);
    rx_if.bit_in = 1'b1;
    tick(2);
    check_eq("t5_data", rx_if.data_out, 5'h12);
    check_eq("t5_dv_count", dv_cnt - dv0, 1);
    check_eq("t5_dv_time", last_dv_cyc, e0 + 27);
    check_eq("never_both", both_cnt, 0);

    // 6: M=8, CPB=1 from the serializer. The start bit must cover both the
    // detect edge and the re-check edge, so the load is held for two cycles.
    dv80 = dv8_cnt; fe80 = fe8_cnt; bz80 = busy8_cnt;
    piso_load = 1'b1;
    tick(1);
    l = cyc;
    tick(1);
    piso_load = 1'b0;
    tick(20);
    check_eq("t6_dv_count", dv8_cnt - dv80, 1);
    check_eq("t6_fe_count", fe8_cnt - fe80, 0);
    check_eq("t6_dv_time", last_dv8_cyc, l + 11);
    check_eq("t6_data", if8.data_out, 8'hA5);
    check_eq("t6_busy_after", if8.busy, 1'b0);
    check_eq("t6_busy_cycles", busy8_cnt - bz80, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
